// File: rtl/link_slave_rx.sv
// link_slave_rx: slave end of the 5-lane board-to-board serial link. It synchronises, deserialises and classifies frames.
// Define LINK_PARITY_EN to add a trailing even-parity bit to every lane.
module link_slave_rx #(
   parameter int DATA_BITS   = 16,
   parameter int HDR_BITS    = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   serial_clk_in,
   input  logic                   serial_in_h,
   input  logic                   serial_in_0,
   input  logic                   serial_in_1,
   input  logic                   serial_in_2,
   input  logic                   serial_in_3,
   output logic                   pkt_valid,
   input  logic                   pkt_ready,
   output logic [1:0]             pkt_type,
   output logic [HDR_BITS-1:0]    pkt_hdr,
   output logic [4*DATA_BITS-1:0] pkt_data,
   output logic                   ack_req,
   output logic                   ack_req_seq,
   output logic                   ack_received,
   output logic                   ack_seqNum,
   output logic                   err_timeout,
   output logic                   err_overflow,
   output logic                   err_parity
);

`ifdef LINK_PARITY_EN
   localparam int FRAME_BITS = DATA_BITS + 1;
`else
   localparam int FRAME_BITS = DATA_BITS;
`endif
   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] HDR_END  = CNT_W'(HDR_BITS);
   localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_BITS);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0]       TYPE_ACK = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0][5:0] sync_q;
   logic                        sync_clk_d;
   logic [5:0]                  raw;
   logic                        sync_clk, sync_h, link_edge;
   logic [3:0]                  sync_d;

   logic [HDR_BITS-1:0]         sh_h;
   logic [3:0][DATA_BITS-1:0]   sh_d;
   logic [CNT_W-1:0]            bit_cnt;
   logic [TO_W-1:0]             idle_cnt;
   logic                        last_seq;
   logic                        timeout;
   logic                        parity_bad;
   logic [1:0]                  rx_type;
   logic                        rx_seq;

   assign raw       = {serial_clk_in, serial_in_h, serial_in_3, serial_in_2, serial_in_1, serial_in_0};
   assign sync_clk  = sync_q[SYNC_STAGES-1][5];
   assign sync_h    = sync_q[SYNC_STAGES-1][4];
   assign sync_d    = sync_q[SYNC_STAGES-1][3:0];
   assign link_edge = sync_clk & ~sync_clk_d;

   always_ff @(posedge clk) begin
      // NOTE: synchronisers reset to the idle-high line state, so reset release never fakes a link-clock edge.
      if (rst) begin
         sync_q     <= '1;
         sync_clk_d <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], raw};
         sync_clk_d <= sync_clk;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   assign timeout = (state == RECV) && !link_edge && (idle_cnt == TO_LAST);
   assign rx_type = sh_h[HDR_BITS-1 -: 2];
   assign rx_seq  = sh_h[0];

   // NOTE: every variable of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (link_edge && !sync_h) state_nxt = RECV;
         RECV: begin
            if (timeout)                               state_nxt = IDLE;
            else if (link_edge && bit_cnt == LAST_BIT) state_nxt = CHECK;
         end
         CHECK:   state_nxt = (link_edge && !sync_h) ? RECV : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef LINK_PARITY_EN
   // Running XOR of every bit per lane, parity bit included; even parity leaves it 0.
   logic [4:0] par_acc;

   always_ff @(posedge clk) begin
      if (rst)                                  par_acc <= '0;
      else if (state != RECV || timeout)        par_acc <= '0;
      else if (link_edge)                       par_acc <= par_acc ^ {sync_h, sync_d};
   end

   assign parity_bad = |par_acc;

   always_ff @(posedge clk) begin
      if (rst) err_parity <= 1'b0;
      else     err_parity <= (state == CHECK) && parity_bad;
   end
`else
   assign parity_bad = 1'b0;
   assign err_parity = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_h         <= '0;
         sh_d         <= '0;
         bit_cnt      <= '0;
         idle_cnt     <= '0;
         last_seq     <= 1'b1;
         pkt_valid    <= 1'b0;
         pkt_type     <= '0;
         pkt_hdr      <= '0;
         pkt_data     <= '0;
         ack_req      <= 1'b0;
         ack_req_seq  <= 1'b0;
         ack_received <= 1'b0;
         ack_seqNum   <= 1'b0;
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         ack_req      <= 1'b0;
         ack_received <= 1'b0;
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
         if (pkt_valid && pkt_ready) pkt_valid <= 1'b0;

         case (state)
            RECV: begin
               if (timeout) begin
                  err_timeout <= 1'b1;
                  sh_h        <= '0;
                  sh_d        <= '0;
               end else if (link_edge) begin
                  // Only the leading bits are kept; trailing header and parity bits fall through.
                  if (bit_cnt < HDR_END) sh_h <= {sh_h[HDR_BITS-2:0], sync_h};
                  if (bit_cnt < DATA_END) begin
                     for (int i = 0; i < 4; i++) sh_d[i] <= {sh_d[i][DATA_BITS-2:0], sync_d[i]};
                  end
                  bit_cnt  <= bit_cnt + 1'b1;
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            CHECK: begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
               if (!parity_bad) begin
                  if (rx_type == TYPE_ACK) begin
                     ack_received <= 1'b1;
                     ack_seqNum   <= rx_seq;
                  end else if (rx_seq == last_seq) begin
                     ack_req     <= 1'b1;
                     ack_req_seq <= rx_seq;
                  end else if (!pkt_valid || pkt_ready) begin
                     pkt_valid   <= 1'b1;
                     pkt_type    <= rx_type;
                     pkt_hdr     <= sh_h;
                     for (int i = 0; i < 4; i++) pkt_data[i*DATA_BITS +: DATA_BITS] <= sh_d[i];
                     last_seq    <= rx_seq;
                     ack_req     <= 1'b1;
                     ack_req_seq <= rx_seq;
                  end else begin
                     err_overflow <= 1'b1;
                  end
               end
            end
            default: begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_link_slave_rx.sv
// tb_link_slave_rx: randomized frames on the link, compared against a frame-level model of the receiver.
module tb_link_slave_rx;

   localparam int DATA_BITS   = 16;
   localparam int HDR_BITS    = 8;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT_CYC = 64;
   localparam int HALF        = 4;
`ifdef LINK_PARITY_EN
   localparam int FRAME_BITS = DATA_BITS + 1;
   localparam bit PAR        = 1'b1;
`else
   localparam int FRAME_BITS = DATA_BITS;
   localparam bit PAR        = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   serial_clk_in = 1'b0;
   logic                   serial_in_h = 1'b1;
   logic                   serial_in_0 = 1'b1;
   logic                   serial_in_1 = 1'b1;
   logic                   serial_in_2 = 1'b1;
   logic                   serial_in_3 = 1'b1;
   logic                   pkt_ready = 1'b0;
   logic                   pkt_valid;
   logic [1:0]             pkt_type;
   logic [HDR_BITS-1:0]    pkt_hdr;
   logic [4*DATA_BITS-1:0] pkt_data;
   logic                   ack_req, ack_req_seq, ack_received, ack_seqNum;
   logic                   err_timeout, err_overflow, err_parity;

   always #10 clk = ~clk;

   link_slave_rx #(
      .DATA_BITS(DATA_BITS), .HDR_BITS(HDR_BITS), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .serial_clk_in(serial_clk_in), .serial_in_h(serial_in_h),
      .serial_in_0(serial_in_0), .serial_in_1(serial_in_1), .serial_in_2(serial_in_2), .serial_in_3(serial_in_3),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_type(pkt_type), .pkt_hdr(pkt_hdr), .pkt_data(pkt_data),
      .ack_req(ack_req), .ack_req_seq(ack_req_seq), .ack_received(ack_received), .ack_seqNum(ack_seqNum),
      .err_timeout(err_timeout), .err_overflow(err_overflow), .err_parity(err_parity)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Pulse counters, each written only here.
   int c_req = 0, c_rcv = 0, c_to = 0, c_ovf = 0, c_par = 0;
   always @(negedge clk) begin
      if (ack_req)      c_req++;
      if (ack_received) c_rcv++;
      if (err_timeout)  c_to++;
      if (err_overflow) c_ovf++;
      if (err_parity)   c_par++;
   end

   // Frame-level model of what the consumer should see.
   logic        m_valid = 1'b0, m_last = 1'b1, m_ack_seq = 1'b0, m_ack_req_seq = 1'b0;
   logic [1:0]  m_type = '0;
   logic [7:0]  m_hdr = '0;
   logic [63:0] m_data = '0;

   task automatic send_bit(input logic h, input logic [3:0] d);
      serial_in_h = h;
      {serial_in_3, serial_in_2, serial_in_1, serial_in_0} = d;
      repeat (HALF) @(posedge clk);
      serial_clk_in = 1'b1;
      repeat (HALF) @(posedge clk);
      serial_clk_in = 1'b0;
   endtask

   task automatic send_frame(input logic [DATA_BITS-1:0] h, input logic [DATA_BITS-1:0] d0,
                             input logic [DATA_BITS-1:0] d1, input logic [DATA_BITS-1:0] d2,
                             input logic [DATA_BITS-1:0] d3, input bit corrupt, input int nbits);
      logic [DATA_BITS-1:0]  dd [5];
      logic [FRAME_BITS-1:0] w  [5];
      dd = '{h, d0, d1, d2, d3};
      for (int i = 0; i < 5; i++) begin
`ifdef LINK_PARITY_EN
         w[i] = {dd[i], ^dd[i]};
`else
         w[i] = dd[i];
`endif
      end
      if (corrupt) w[3][FRAME_BITS-DATA_BITS+7] = ~w[3][FRAME_BITS-DATA_BITS+7];
      send_bit(1'b0, 4'hF);
      for (int b = FRAME_BITS - 1; b >= FRAME_BITS - nbits; b--)
         send_bit(w[0][b], {w[4][b], w[3][b], w[2][b], w[1][b]});
      serial_in_h = 1'b1;
      {serial_in_3, serial_in_2, serial_in_1, serial_in_0} = 4'hF;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".valid"},    pkt_valid,   m_valid);
      check({tag, ".data"},     pkt_data,    m_data);
      check({tag, ".hdr"},      pkt_hdr,     m_hdr);
      check({tag, ".type"},     pkt_type,    m_type);
      check({tag, ".ack_seq"},  ack_seqNum,  m_ack_seq);
      check({tag, ".req_seq"},  ack_req_seq, m_ack_req_seq);
   endtask

   task automatic do_frame(input string tag, input logic [15:0] h, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3, input bit corrupt, input bit ready_mode);
      int b_req, b_rcv, b_to, b_ovf, b_par;
      int e_req, e_rcv, e_ovf, e_par;
      logic [1:0] typ;
      logic       seq;
      b_req = c_req; b_rcv = c_rcv; b_to = c_to; b_ovf = c_ovf; b_par = c_par;
      e_req = 0; e_rcv = 0; e_ovf = 0; e_par = 0;
      typ = h[15:14];
      seq = h[8];
      if (ready_mode) begin
         @(negedge clk);
         pkt_ready = 1'b1;
         m_valid   = 1'b0;
      end
      send_frame(h, d0, d1, d2, d3, corrupt, FRAME_BITS);
      repeat (6) @(posedge clk);
      @(negedge clk);
      pkt_ready = 1'b0;
      @(negedge clk);
      if (corrupt && PAR) e_par = 1;
      else if (typ == 2'b11) begin
         e_rcv = 1;
         m_ack_seq = seq;
      end else if (seq == m_last) begin
         e_req = 1;
         m_ack_req_seq = seq;
      end else if (!m_valid) begin
         e_req = 1;
         m_ack_req_seq = seq;
         m_last  = seq;
         m_data  = {d3, d2, d1, d0};
         m_hdr   = h[15:8];
         m_type  = typ;
         m_valid = !ready_mode;
      end else e_ovf = 1;
      check({tag, ".n_ack_req"},  c_req - b_req, e_req);
      check({tag, ".n_ack_rcv"},  c_rcv - b_rcv, e_rcv);
      check({tag, ".n_timeout"},  c_to - b_to,   0);
      check({tag, ".n_overflow"}, c_ovf - b_ovf, e_ovf);
      check({tag, ".n_parity"},   c_par - b_par, e_par);
      check_regs(tag);
   endtask

   task automatic pop(input string tag);
      @(negedge clk);
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
      m_valid   = 1'b0;
      @(negedge clk);
      check({tag, ".popped"}, pkt_valid, 1'b0);
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_last = 1'b1; m_ack_seq = 1'b0; m_ack_req_seq = 1'b0;
      m_type = '0; m_hdr = '0; m_data = '0;
   endtask

   initial begin
      int b_to, b_req, b_rcv, lat;
      logic [1:0] rt;

      repeat (4) @(negedge clk);
      check("reset.ack_req", {ack_req, ack_received, err_timeout, err_overflow, err_parity}, 5'b0);
      check_regs("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      do_frame("t1", 16'h0000, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      check("t1.payload", pkt_data, 64'h0001_FFFF_5A5A_A5A5);
      pop("t1");
      do_frame("t2_dup", 16'h0000, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      do_frame("t3_ack", 16'hC100, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b0, 1'b0);

      b_to = c_to; b_req = c_req; b_rcv = c_rcv;
      send_frame(16'h0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 5);
      lat = 0;
      while (c_to == b_to && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      check("t4.timeout_seen", c_to - b_to, 1);
      check("t4.timeout_lat", (lat >= TIMEOUT_CYC - 8) && (lat <= TIMEOUT_CYC + SYNC_STAGES + 4), 1'b1);
      check("t4.no_side_pulses", (c_req - b_req) + (c_rcv - b_rcv), 0);
      do_frame("t4_after", 16'h0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b0);

      b_req = c_req;
      send_frame(16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b0, 8);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_mid.no_pulses", c_req - b_req, 0);
      check_regs("rst_mid");

      do_frame("t5_seq0", 16'h4000, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 1'b0, 1'b0);
      do_frame("t5_seq1", 16'h8100, 16'h1357, 16'h2468, 16'h9999, 16'h7777, 1'b0, 1'b0);
      pop("t5");

`ifdef LINK_PARITY_EN
      do_frame("t6_bad",   16'h0100, 16'hCAFE, 16'hBEEF, 16'h0080, 16'h1234, 1'b1, 1'b0);
      do_frame("t6_clean", 16'h0100, 16'hCAFE, 16'hBEEF, 16'h0080, 16'h1234, 1'b0, 1'b0);
      pop("t6");
`endif

      for (int n = 0; n < 40; n++) begin
         if (m_valid && $urandom_range(0, 1) == 1) pop("rnd");
         rt = 2'($urandom_range(0, 3));
         do_frame("rnd",
                  {rt, 5'($urandom), 1'($urandom), 8'($urandom)},
                  16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  PAR && ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 3) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
